iterative_divider: RTL and testbench

- Sequential 64-bit integer divider; the inverse companion to the combinational Thirty_Two_Bit_Multiplier in the LEGv8 datapath ALU.
- Serves UDIV/SDIV with a start/busy/done handshake.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- Sign correction is applied in a final cycle.

---
 rtl/iterative_divider_if.sv | 39 +++
 rtl/iterative_divider.sv | 193 +++++++++++++++++++
 tb/tb_iterative_divider.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/iterative_divider_if.sv
// Request/response bundle for the iterative divider: operands and start go
// in; busy, the done pulse and the held results come back.
interface iterative_divider_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output is_signed,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  is_signed,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/iterative_divider.sv
// Sequential restoring divider for UDIV/SDIV. Operands are reduced to
// magnitudes on acceptance, one quotient bit is produced per clock in RUN,
// and the signs are re-applied in the single FIX cycle. A zero divisor skips
// RUN and goes straight to FIX with the quotient forced to zero and the raw
// dividend parked as the remainder.
module iterative_divider #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    iterative_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    // Two's complement negation when neg is set; WIDTH-bit wrap-around, so the
    // most negative value maps onto itself, which is exactly its magnitude
    // when read as unsigned.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                                input logic             neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + W_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;
    logic             iter_s;
    logic             fix_s;

    logic             div_zero_s;
    logic             a_neg_s;
    logic             b_neg_s;

    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dvd_r;      // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] dvs_r;      // divisor magnitude
    logic [WIDTH-1:0] p_r;        // partial remainder (always < divisor)
    logic [WIDTH-1:0] q_r;        // quotient magnitude, shifted in LSB first
    logic             q_neg_r;
    logic             r_neg_r;
    logic             zero_r;

    logic [WIDTH:0]   p_shift_s;  // WIDTH+1 bit trial value {P, next bit}
    logic             p_ge_s;
    logic [WIDTH-1:0] p_sub_s;

    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    assign div_zero_s = (bus.divisor == W_ZERO);
    assign a_neg_s    = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg_s    = bus.is_signed & bus.divisor[WIDTH-1];

    // The difference fits in WIDTH bits whenever the trial value is >= the
    // divisor, so the low WIDTH bits of the subtraction are exact.
    assign p_shift_s  = {p_r, dvd_r[WIDTH-1]};
    assign p_ge_s     = (p_shift_s >= {1'b0, dvs_r});
    assign p_sub_s    = p_shift_s[WIDTH-1:0] - dvs_r;

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        iter_s       = 1'b0;
        fix_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    if (div_zero_s) begin
                        state_next_s = FIX;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                iter_s = 1'b1;
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX: begin
                fix_s        = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture, shift-subtract iterations and sign-corrected results.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= CNT_ZERO;
            dvd_r       <= W_ZERO;
            dvs_r       <= W_ZERO;
            p_r         <= W_ZERO;
            q_r         <= W_ZERO;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            zero_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= W_ZERO;
            remainder_r <= W_ZERO;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                dvd_r  <= neg_if(bus.dividend, a_neg_s);
                dvs_r  <= neg_if(bus.divisor, b_neg_s);
                q_r    <= W_ZERO;
                cnt_r  <= CNT_LAST;
                zero_r <= div_zero_s;
                busy_r <= 1'b1;
                dbz_r  <= 1'b0;
                if (div_zero_s) begin
                    // Park the untouched dividend so FIX returns it as-is.
                    p_r     <= bus.dividend;
                    q_neg_r <= 1'b0;
                    r_neg_r <= 1'b0;
                end else begin
                    p_r     <= W_ZERO;
                    q_neg_r <= a_neg_s ^ b_neg_s;
                    r_neg_r <= a_neg_s;
                end
            end else if (iter_s) begin
                if (p_ge_s) begin
                    p_r <= p_sub_s;
                end else begin
                    p_r <= p_shift_s[WIDTH-1:0];
                end
                q_r   <= {q_r[WIDTH-2:0], p_ge_s};
                dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                if (cnt_r != CNT_ZERO) begin
                    cnt_r <= cnt_r - CNT_ONE;
                end else begin
                    cnt_r <= CNT_ZERO;
                end
            end else if (fix_s) begin
                quotient_r  <= neg_if(q_r, q_neg_r);
                remainder_r <= neg_if(p_r, r_neg_r);
                dbz_r       <= zero_r;
                done_r      <= 1'b1;
                busy_r      <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: expected results are queued when an
// operation is started and compared when done pulses.
module tb_iterative_divider;
    localparam int W = 64;

    logic clk = 1'b0;
    logic reset;

    iterative_divider_if #(.WIDTH(W)) bus ();

    iterative_divider #(.WIDTH(W), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q  = q;
        e.r  = r;
        e.dz = dz;
        sb.push_back(e);
    endtask

    // Reference: truncating division on magnitudes, signs re-applied.
    task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic na, nb;
        logic [W-1:0] ua, ub, uq, ur;
        if (b == 64'd0) begin
            push(64'd0, a, 1'b1);
        end else begin
            na = s & a[W-1];
            nb = s & b[W-1];
            ua = na ? (~a + 64'd1) : a;
            ub = nb ? (~b + 64'd1) : b;
            uq = ua / ub;
            ur = ua % ub;
            push((na ^ nb) ? (~uq + 64'd1) : uq, na ? (~ur + 64'd1) : ur, 1'b0);
        end
    endtask

    // Present a request for one edge (T0), then withdraw it.
    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat, input bit hold);
        int   n    = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        chk({tag, " latency"}, 64'(n), 64'(lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " quotient"}, bus.quotient, e.q);
            chk({tag, " remainder"}, bus.remainder, e.r);
            chk({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(e.dz));
            if (hold) begin
                @(posedge clk);
                #1;
                chk({tag, " done_drops"}, 64'(bus.done), 64'd0);
                chk({tag, " q_held"}, bus.quotient, e.q);
                chk({tag, " r_held"}, bus.remainder, e.r);
            end
        end else begin
            total++;
            bad++;
            $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn;
        logic s;
        logic [W-1:0] a, b;

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = 64'd0;
        bus.divisor   = 64'd0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst dbz", 64'(bus.div_by_zero), 64'd0);
        chk("rst q", bus.quotient, 64'd0);
        chk("rst r", bus.remainder, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Unsigned 1000/7
        drive(1'b0, 64'd1000, 64'd7);
        push(64'd142, 64'd6, 1'b0);
        chk("udiv busy", 64'(bus.busy), 64'd1);
        wait_done("udiv", 65, 1'b1);

        // Signed sweep
        drive(1'b1, -64'sd7, 64'd2);
        push(-64'sd3, -64'sd1, 1'b0);
        wait_done("sdiv_m7_2", 65, 1'b0);
        drive(1'b1, 64'd7, -64'sd2);
        push(-64'sd3, 64'd1, 1'b0);
        wait_done("sdiv_7_m2", 65, 1'b0);
        drive(1'b1, -64'sd7, -64'sd2);
        push(64'd3, -64'sd1, 1'b0);
        wait_done("sdiv_m7_m2", 65, 1'b0);

        // Full unsigned range
        drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        push(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        wait_done("umax", 65, 1'b0);

        // Divide by zero, then a normal op must clear the flag
        drive(1'b0, 64'd42, 64'd0);
        push(64'd0, 64'd42, 1'b1);
        wait_done("dz", 1, 1'b1);
        drive(1'b0, 64'd9, 64'd4);
        push(64'd2, 64'd1, 1'b0);
        wait_done("after_dz", 65, 1'b0);

        // Signed overflow wraps
        drive(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        push(64'h8000_0000_0000_0000, 64'd0, 1'b0);
        wait_done("ovf", 65, 1'b0);

        // Start while busy is ignored; start in the done cycle is accepted
        drive(1'b0, 64'd500, 64'd3);
        push(64'd166, 64'd2, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        drive(1'b0, 64'd9, 64'd3);
        chk("ign busy", 64'(bus.busy), 64'd1);
        wait_done("ign", 55, 1'b0);
        drive(1'b0, 64'd100, 64'd10);
        push(64'd10, 64'd0, 1'b0);
        wait_done("b2b", 65, 1'b1);
        chk("b2b sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-operation at T0+30
        drive(1'b0, 64'd12345, 64'd6);
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst busy", 64'(bus.busy), 64'd0);
        chk("mid_rst done", 64'(bus.done), 64'd0);
        chk("mid_rst q", bus.quotient, 64'd0);
        chk("mid_rst r", bus.remainder, 64'd0);
        dn = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0) dn++;
        end
        chk("mid_rst no_done", 64'(dn), 64'd0);
        drive(1'b1, -64'sd100, 64'd7);
        push(-64'sd14, -64'sd2, 1'b0);
        wait_done("post_rst", 65, 1'b0);

        // Random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 62);
            drive(s, a, b);
            model(s, a, b);
            wait_done("rand", (b == 64'd0) ? 1 : 65, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
